// File: rtl/instr_fetch_if.sv
// Instruction-memory fetch bus: request/address out of the IF stage, ack/data back from memory.
interface instr_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch.sv
// IF stage: owns the PC, fetches over a req/ack bus and loads the IF/ID register,
// absorbing stalls, ID-resolved branch redirects and variable memory latency.
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    instr_fetch_if.master        imem,
    input  logic                 stall_i,
    input  logic                 branch_taken_i,
    input  logic [31:0]          branch_target_i,
    output logic [31:0]          if_id_instr_o,
    output logic [31:0]          if_id_pc4_o,
    output logic                 if_id_valid_o
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] drain_addr_q, drain_addr_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;
    logic [31:0] if_id_pc4_q, if_id_pc4_d;
    logic        if_id_valid_q, if_id_valid_d;

    logic        req;
    logic        ack_hit;
    logic [31:0] pc_plus4;
    logic [31:0] target_aligned;
    logic        unused_target_bits;

    // Redirect targets are forced word-aligned, so their low bits never reach the PC.
    assign target_aligned     = {branch_target_i[31:2], 2'b00};
    assign unused_target_bits = ^branch_target_i[1:0];
    assign pc_plus4           = pc_q + 32'd4;

    assign req     = !rst_i && ((state_q == FETCH) || (state_q == DRAIN));
    assign ack_hit = imem.imem_ack && req;

    assign imem.imem_req  = req;
    assign imem.imem_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;

    assign if_id_instr_o = if_id_instr_q;
    assign if_id_pc4_o   = if_id_pc4_q;
    assign if_id_valid_o = if_id_valid_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        hold_d        = hold_q;
        drain_addr_d  = drain_addr_q;
        if_id_instr_d = if_id_instr_q;
        if_id_pc4_d   = if_id_pc4_q;
        if_id_valid_d = if_id_valid_q;

        unique case (state_q)
            FETCH: begin
                if (branch_taken_i) begin
                    pc_d          = target_aligned;
                    if_id_instr_d = NOP_INSTR;
                    if_id_valid_d = 1'b0;
                    // The bus cannot be abandoned mid-request, so wait out the stale fetch.
                    if (!ack_hit) begin
                        drain_addr_d = pc_q;
                        state_d      = DRAIN;
                    end
                end else if (ack_hit && !stall_i) begin
                    if_id_instr_d = imem.imem_rdata;
                    if_id_pc4_d   = pc_plus4;
                    if_id_valid_d = 1'b1;
                    pc_d          = pc_plus4;
                end else if (ack_hit && stall_i) begin
                    hold_d  = imem.imem_rdata;
                    pc_d    = pc_plus4;
                    state_d = HOLD;
                end else if (!stall_i) begin
                    if_id_instr_d = NOP_INSTR;
                    if_id_valid_d = 1'b0;
                end
            end

            HOLD: begin
                if (branch_taken_i) begin
                    pc_d          = target_aligned;
                    hold_d        = '0;
                    if_id_instr_d = NOP_INSTR;
                    if_id_valid_d = 1'b0;
                    state_d       = FETCH;
                end else if (!stall_i) begin
                    // pc_q was already advanced when the word was captured.
                    if_id_instr_d = hold_q;
                    if_id_pc4_d   = pc_q;
                    if_id_valid_d = 1'b1;
                    state_d       = FETCH;
                end
            end

            DRAIN: begin
                if (branch_taken_i) begin
                    pc_d          = target_aligned;
                    if_id_instr_d = NOP_INSTR;
                    if_id_valid_d = 1'b0;
                end
                if (ack_hit) begin
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            hold_q        <= '0;
            drain_addr_q  <= '0;
            if_id_instr_q <= NOP_INSTR;
            if_id_pc4_q   <= '0;
            if_id_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            hold_q        <= hold_d;
            drain_addr_q  <= drain_addr_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_pc4_q   <= if_id_pc4_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: memory returns address-as-data, ack is driven per cycle.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic        ackEn;
    logic [31:0] ifIdInstr;
    logic [31:0] ifIdPc4;
    logic        ifIdValid;

    int vectors;
    int miscompares;

    instr_fetch_if bus ();

    assign bus.imem_ack   = ackEn;
    assign bus.imem_rdata = bus.imem_addr;

    instr_fetch #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(32'h0000_0000)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .imem           (bus.master),
        .stall_i        (stall),
        .branch_taken_i (branchTaken),
        .branch_target_i(branchTarget),
        .if_id_instr_o  (ifIdInstr),
        .if_id_pc4_o    (ifIdPc4),
        .if_id_valid_o  (ifIdValid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Inputs hold for the cycle leading into the next rising edge; outputs are sampled 1ns after it.
    task automatic applyStimulus(input logic r, input logic s, input logic bt,
                                 input logic [31:0] tgt, input logic a);
        rst          = r;
        stall        = s;
        branchTaken  = bt;
        branchTarget = tgt;
        ackEn        = a;
        @(posedge clk);
        #1;
    endtask

    task automatic checkIfId(input string tag, input logic [31:0] instr,
                             input logic [31:0] pc4, input logic valid);
        checkOutput({tag, ".instr"}, ifIdInstr, instr);
        checkOutput({tag, ".pc4"}, ifIdPc4, pc4);
        checkOutput({tag, ".valid"}, {31'd0, ifIdValid}, {31'd0, valid});
    endtask

    task automatic checkBus(input string tag, input logic req, input logic [31:0] addr);
        checkOutput({tag, ".req"}, {31'd0, bus.imem_req}, {31'd0, req});
        if (req) checkOutput({tag, ".addr"}, bus.imem_addr, addr);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;

        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        checkBus("reset", 1'b0, 32'h0);
        checkIfId("reset", 32'h0, 32'h0, 1'b0);

        // Zero-wait stream from address 0 until pc reaches 0x10.
        rst = 1'b0;
        #1;
        checkBus("first_req", 1'b1, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            checkBus("stream", 1'b1, 32'(4 * i));
            checkIfId("stream", 32'(4 * (i - 1)), 32'(4 * i), 1'b1);
        end

        // Three-cycle latency at 0x10.
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkBus("lat_w1", 1'b1, 32'h10);
        checkIfId("lat_w1", 32'h0, 32'h10, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkBus("lat_w2", 1'b1, 32'h10);
        checkIfId("lat_w2", 32'h0, 32'h10, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkBus("lat_ack", 1'b1, 32'h14);
        checkIfId("lat_ack", 32'h10, 32'h14, 1'b1);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            checkIfId("pre_stall", 32'(32'h14 + 4 * i), 32'(32'h18 + 4 * i), 1'b1);
        end
        checkBus("pre_stall", 1'b1, 32'h20);

        // Stall for four cycles while 0x20 is acked; ack stays high to show it is ignored in HOLD.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
            checkBus("stall", 1'b0, 32'h0);
            checkIfId("stall", 32'h1C, 32'h20, 1'b1);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkBus("unstall", 1'b1, 32'h24);
        checkIfId("unstall", 32'h20, 32'h24, 1'b1);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            checkIfId("to_40", 32'(32'h24 + 4 * i), 32'(32'h28 + 4 * i), 1'b1);
        end
        checkBus("to_40", 1'b1, 32'h40);

        // Branch to 0x103 while 0x40 is outstanding; ack arrives two cycles later.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h103, 1'b0);
        checkBus("br_drain1", 1'b1, 32'h40);
        checkIfId("br_drain1", 32'h0, 32'h40, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkBus("br_drain2", 1'b1, 32'h40);
        checkIfId("br_drain2", 32'h0, 32'h40, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkBus("br_acked", 1'b1, 32'h100);
        checkIfId("br_acked", 32'h0, 32'h40, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkBus("br_target", 1'b1, 32'h104);
        checkIfId("br_target", 32'h100, 32'h104, 1'b1);

        // Branch and stall together while holding 0x104.
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        checkBus("hold_in", 1'b0, 32'h0);
        checkIfId("hold_in", 32'h100, 32'h104, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h200, 1'b0);
        checkBus("hold_br", 1'b1, 32'h200);
        checkOutput("hold_br.instr", ifIdInstr, 32'h0);
        checkOutput("hold_br.valid", {31'd0, ifIdValid}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkBus("hold_br_fetch", 1'b1, 32'h204);
        checkIfId("hold_br_fetch", 32'h200, 32'h204, 1'b1);

        // Misaligned redirect to the top word, then wrap of pc+4.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1);
        checkBus("wrap_redirect", 1'b1, 32'hFFFF_FFFC);
        checkOutput("wrap_redirect.valid", {31'd0, ifIdValid}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkBus("wrap", 1'b1, 32'h0);
        checkIfId("wrap", 32'hFFFF_FFFC, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkIfId("after_wrap", 32'h0, 32'h4, 1'b1);

        // Reset while waiting on the fetch of 0x8.
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkBus("mid_wait", 1'b1, 32'h8);
        checkIfId("mid_wait", 32'h0, 32'h8, 1'b0);
        rst = 1'b1;
        #1;
        checkBus("rst_comb", 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        checkBus("rst_mid", 1'b0, 32'h0);
        checkIfId("rst_mid", 32'h0, 32'h0, 1'b0);
        rst = 1'b0;
        #1;
        checkBus("post_rst", 1'b1, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkIfId("post_rst", 32'h0, 32'h4, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
